dma_mem_responder: RTL and testbench

Memory-side responder for the ROM-to-RAM DMA engine. It holds a source ROM array and a destination RAM array. It answers the DMA's ROM read requests with a fixed, parameterised latency, and it accepts the DMA's RAM write beats. It also provides a ROM preload port and a RAM readback port, so benches and the top level can seed the source and check the destination.

---
 rtl/dma_pkg.sv | 12 +
 rtl/dma_rd_pipe.sv | 48 ++++
 rtl/dma_mem_responder.sv | 92 +++++++++
 tb/tb_dma_mem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Types and limits shared by the ROM-to-RAM DMA engine and its memory-side responder.
package dma_pkg;

   localparam int unsigned DMA_DATA_WIDTH   = 8;
   localparam int unsigned DMA_ADDR_WIDTH   = 4;
   localparam int unsigned MAX_READ_LATENCY = 8;

   typedef logic [DMA_ADDR_WIDTH-1:0] addr_t;
   typedef logic [DMA_DATA_WIDTH-1:0] data_t;
   typedef logic [DMA_ADDR_WIDTH:0]   cnt_t;

endpackage

// File: rtl/dma_rd_pipe.sv
// Valid+data delay line of DEPTH stages with synchronous clear.
// A stage loads data only when its incoming valid is set, so the final data holds between responses.
module dma_rd_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             issue,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];
   logic [DEPTH-1:0] vin;
   logic [WIDTH-1:0] din [DEPTH];

   always_comb begin
      vin    = '0;
      din[0] = in_data;
      vin[0] = in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         vin[i] = vld[i-1];
         din[i] = dat[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         vld <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) dat[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            vld[i] <= vin[i];
            if (vin[i]) dat[i] <= din[i];
         end
      end
   end

   // High in the cycle before out_valid rises, so a counter lands together with the response.
   assign issue     = vin[DEPTH-1];
   assign out_valid = vld[DEPTH-1];
   assign out_data  = dat[DEPTH-1];

endmodule

// File: rtl/dma_mem_responder.sv
// Memory-side responder: source ROM with fixed-latency reads and preload port,
// destination RAM with write port and one-cycle readback port.
module dma_mem_responder
   import dma_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DMA_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DMA_ADDR_WIDTH,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rom_addr_valid,
   input  logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_data_valid,
   output logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  ram_addr_valid,
   input  logic                  ram_wea,
   input  logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_data,
   input  logic                  load_en,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  rb_en,
   input  logic [ADDR_WIDTH-1:0] rb_addr,
   output logic                  rb_valid,
   output logic [DATA_WIDTH-1:0] rb_data,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic [ADDR_WIDTH:0]   wr_count
);

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
         $error("dma_mem_responder: READ_LATENCY must be in 1..8");
      end
   endgenerate

   localparam int unsigned    DEPTH   = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

   logic [DATA_WIDTH-1:0] rom_mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_mem [DEPTH];

   logic rom_accept;
   logic ram_write;
   logic rsp_issue;

   assign rom_accept = rom_addr_valid & ~reset;
   assign ram_write  = ram_wea & ram_addr_valid & ~reset;

   // Combinational array read feeds stage 0, giving read-first against a same-cycle preload.
   dma_rd_pipe #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (READ_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .clear     (reset),
      .in_valid  (rom_accept),
      .in_data   (rom_mem[rom_addr]),
      .issue     (rsp_issue),
      .out_valid (rom_data_valid),
      .out_data  (rom_data)
   );

   always_ff @(posedge clk) begin
      if (!reset && load_en) rom_mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk) begin
      if (ram_write) ram_mem[ram_addr] <= ram_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rb_valid <= 1'b0;
         rb_data  <= '0;
      end else begin
         rb_valid <= rb_en;
         if (rb_en) rb_data <= ram_mem[rb_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rsp_issue) rd_count <= rd_count + CNT_ONE;
         if (ram_write) wr_count <= wr_count + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_dma_mem_responder.sv
// Directed bench for dma_mem_responder: default latency instance plus a READ_LATENCY=1 instance.
module tb_dma_mem_responder;

   localparam int DW = 8;
   localparam int AW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          rom_addr_valid, ram_addr_valid, ram_wea, load_en, rb_en;
   logic [AW-1:0] rom_addr, ram_addr, load_addr, rb_addr;
   logic [DW-1:0] ram_data, load_data;
   logic          rom_data_valid, rb_valid;
   logic [DW-1:0] rom_data, rb_data;
   logic [AW:0]   rd_count, wr_count;

   logic          b_rom_addr_valid, b_ram_addr_valid, b_ram_wea, b_load_en, b_rb_en;
   logic [AW-1:0] b_rom_addr, b_ram_addr, b_load_addr, b_rb_addr;
   logic [DW-1:0] b_ram_data, b_load_data;
   logic          b_rom_data_valid, b_rb_valid;
   logic [DW-1:0] b_rom_data, b_rb_data;
   logic [AW:0]   b_rd_count, b_wr_count;

   int total = 0;
   int bad   = 0;

   dma_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .rom_addr_valid(rom_addr_valid), .rom_addr(rom_addr),
      .rom_data_valid(rom_data_valid), .rom_data(rom_data),
      .ram_addr_valid(ram_addr_valid), .ram_wea(ram_wea),
      .ram_addr(ram_addr), .ram_data(ram_data),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .rb_en(rb_en), .rb_addr(rb_addr), .rb_valid(rb_valid), .rb_data(rb_data),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   dma_mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset),
      .rom_addr_valid(b_rom_addr_valid), .rom_addr(b_rom_addr),
      .rom_data_valid(b_rom_data_valid), .rom_data(b_rom_data),
      .ram_addr_valid(b_ram_addr_valid), .ram_wea(b_ram_wea),
      .ram_addr(b_ram_addr), .ram_data(b_ram_data),
      .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data),
      .rb_en(b_rb_en), .rb_addr(b_rb_addr), .rb_valid(b_rb_valid), .rb_data(b_rb_data),
      .rd_count(b_rd_count), .wr_count(b_wr_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rom_addr_valid = 0; rom_addr = '0; ram_addr_valid = 0; ram_wea = 0;
      ram_addr = '0; ram_data = '0; load_en = 0; load_addr = '0; load_data = '0;
      rb_en = 0; rb_addr = '0;
      b_rom_addr_valid = 0; b_rom_addr = '0; b_ram_addr_valid = 0; b_ram_wea = 0;
      b_ram_addr = '0; b_ram_data = '0; b_load_en = 0; b_load_addr = '0; b_load_data = '0;
      b_rb_en = 0; b_rb_addr = '0;
   endtask

   task automatic load_rom(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load_en = 1; load_addr = a; load_data = d;
      tick();
      load_en = 0;
   endtask

   task automatic write_ram(input logic [AW-1:0] a, input logic [DW-1:0] d);
      ram_wea = 1; ram_addr_valid = 1; ram_addr = a; ram_data = d;
      tick();
      ram_wea = 0; ram_addr_valid = 0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      repeat (3) tick();
      total++; if (rom_data_valid !== 1'b0) begin bad++; $display("FAIL reset_rom_valid got=%b want=0", rom_data_valid); end
      total++; if (rom_data !== 8'h00) begin bad++; $display("FAIL reset_rom_data got=%h want=00", rom_data); end
      total++; if (rb_valid !== 1'b0) begin bad++; $display("FAIL reset_rb_valid got=%b want=0", rb_valid); end
      total++; if (rb_data !== 8'h00) begin bad++; $display("FAIL reset_rb_data got=%h want=00", rb_data); end
      total++; if (rd_count !== 5'd0) begin bad++; $display("FAIL reset_rd_count got=%0d want=0", rd_count); end
      total++; if (wr_count !== 5'd0) begin bad++; $display("FAIL reset_wr_count got=%0d want=0", wr_count); end
      reset = 0;
      tick();
   endtask

   task automatic test_rom_burst();
      logic exp_v;
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 4; i++) load_rom(AW'(i), DW'(8'hA0 + i));
      for (int k = 0; k < 6; k++) begin
         rom_addr_valid = (k < 4);
         rom_addr = AW'(k);
         tick();
         exp_v = (k >= 1 && k <= 4);
         total++;
         if (rom_data_valid !== exp_v) begin bad++; $display("FAIL burst_valid k=%0d got=%b want=%b", k, rom_data_valid, exp_v); end
         if (exp_v) begin
            exp_d = DW'(8'hA0 + k - 1);
            total++;
            if (rom_data !== exp_d) begin bad++; $display("FAIL burst_data k=%0d got=%h want=%h", k, rom_data, exp_d); end
         end
      end
      rom_addr_valid = 0;
      total++; if (rom_data !== 8'hA3) begin bad++; $display("FAIL burst_hold got=%h want=a3", rom_data); end
      total++; if (rd_count !== 5'd4) begin bad++; $display("FAIL burst_rd_count got=%0d want=4", rd_count); end
   endtask

   task automatic test_preload_collision();
      load_rom(4'd5, 8'h11);
      load_en = 1; load_addr = 4'd5; load_data = 8'h22;
      rom_addr_valid = 1; rom_addr = 4'd5;
      tick();
      load_en = 0;
      tick();
      rom_addr_valid = 0;
      total++; if (rom_data_valid !== 1'b1 || rom_data !== 8'h11) begin bad++; $display("FAIL collide_old got=%b/%h want=1/11", rom_data_valid, rom_data); end
      tick();
      total++; if (rom_data_valid !== 1'b1 || rom_data !== 8'h22) begin bad++; $display("FAIL collide_new got=%b/%h want=1/22", rom_data_valid, rom_data); end
      tick();
      total++; if (rom_data_valid !== 1'b0) begin bad++; $display("FAIL collide_idle got=%b want=0", rom_data_valid); end
      total++; if (rd_count !== 5'd6) begin bad++; $display("FAIL collide_rd_count got=%0d want=6", rd_count); end
   endtask

   task automatic test_ram_write();
      write_ram(4'd8, 8'h55);
      write_ram(4'd9, 8'h66);
      write_ram(4'd7, 8'h3C);
      ram_wea = 1; ram_addr_valid = 0; ram_addr = 4'd8; ram_data = 8'hFF;
      tick();
      ram_wea = 0;
      total++; if (wr_count !== 5'd3) begin bad++; $display("FAIL wr_count_gated got=%0d want=3", wr_count); end
      rb_en = 1; rb_addr = 4'd7;
      tick();
      total++; if (rb_valid !== 1'b1 || rb_data !== 8'h3C) begin bad++; $display("FAIL rb_addr7 got=%b/%h want=1/3c", rb_valid, rb_data); end
      rb_addr = 4'd8;
      tick();
      total++; if (rb_data !== 8'h55) begin bad++; $display("FAIL rb_addr8_unchanged got=%h want=55", rb_data); end
      rb_addr = 4'd7; ram_wea = 1; ram_addr_valid = 1; ram_addr = 4'd7; ram_data = 8'h99;
      tick();
      ram_wea = 0; ram_addr_valid = 0;
      total++; if (rb_data !== 8'h3C) begin bad++; $display("FAIL rb_read_first got=%h want=3c", rb_data); end
      tick();
      rb_en = 0;
      total++; if (rb_data !== 8'h99) begin bad++; $display("FAIL rb_after_write got=%h want=99", rb_data); end
      total++; if (wr_count !== 5'd4) begin bad++; $display("FAIL wr_count_after got=%0d want=4", wr_count); end
      tick();
      total++; if (rb_valid !== 1'b0 || rb_data !== 8'h99) begin bad++; $display("FAIL rb_idle_hold got=%b/%h want=0/99", rb_valid, rb_data); end
   endtask

   task automatic test_reset_flush();
      rom_addr_valid = 1; rom_addr = 4'd0;
      tick();
      rom_addr = 4'd1; reset = 1;
      ram_wea = 1; ram_addr_valid = 1; ram_addr = 4'd9; ram_data = 8'h77;
      tick();
      idle();
      reset = 0;
      total++; if (rd_count !== 5'd0 || wr_count !== 5'd0) begin bad++; $display("FAIL flush_counts got=%0d/%0d want=0/0", rd_count, wr_count); end
      total++; if (rom_data !== 8'h00) begin bad++; $display("FAIL flush_rom_data got=%h want=00", rom_data); end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rom_data_valid !== 1'b0) begin bad++; $display("FAIL flush_valid k=%0d got=%b want=0", k, rom_data_valid); end
         tick();
      end
      total++; if (rd_count !== 5'd0) begin bad++; $display("FAIL flush_rd_count got=%0d want=0", rd_count); end
      rb_en = 1; rb_addr = 4'd9;
      tick();
      rb_en = 0;
      total++; if (rb_data !== 8'h66) begin bad++; $display("FAIL flush_write_dropped got=%h want=66", rb_data); end
   endtask

   task automatic test_wr_wrap();
      for (int i = 0; i < 33; i++) write_ram(AW'(i), DW'(i));
      total++; if (wr_count !== 5'd1) begin bad++; $display("FAIL wr_wrap got=%0d want=1", wr_count); end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_d;
      for (int i = 0; i < 16; i++) begin
         b_load_en = 1; b_load_addr = AW'(i); b_load_data = DW'(8'h40 + i * 5);
         tick();
      end
      b_load_en = 0;
      total++; if (b_rom_data_valid !== 1'b0) begin bad++; $display("FAIL l1_pre_valid got=%b want=0", b_rom_data_valid); end
      for (int k = 0; k < 16; k++) begin
         b_rom_addr_valid = 1; b_rom_addr = AW'(k);
         tick();
         exp_d = DW'(8'h40 + k * 5);
         total++;
         if (b_rom_data_valid !== 1'b1 || b_rom_data !== exp_d) begin
            bad++; $display("FAIL l1_rsp k=%0d got=%b/%h want=1/%h", k, b_rom_data_valid, b_rom_data, exp_d);
         end
      end
      b_rom_addr_valid = 0;
      tick();
      total++; if (b_rom_data_valid !== 1'b0) begin bad++; $display("FAIL l1_post_valid got=%b want=0", b_rom_data_valid); end
      total++; if (b_rd_count !== 5'd16) begin bad++; $display("FAIL l1_rd_count got=%0d want=16", b_rd_count); end
   endtask

   initial begin
      test_reset();
      test_rom_burst();
      test_preload_collision();
      test_ram_write();
      test_reset_flush();
      test_wr_wrap();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
